if_fetch_buf: RTL and testbench

Parametrised instruction-fetch stage for the 5-stage LoongArch pipeline. It replaces the fixed single-cycle SRAM fetch with a split request/response SRAM-like interface (addr_ok/data_ok) and up to OUTSTANDING requests in flight. Returned instructions are held in an IBUF_DEPTH-entry instruction buffer that decouples fetch from ID back-pressure. On branch, exception or ertn redirect, in-flight wrong-path responses are cancelled.

---
 rtl/if_fetch_buf_pkg.sv | 24 ++
 rtl/if_fetch_buf_if.sv | 26 ++
 rtl/if_fetch_buf_fetch_fifo.sv | 57 +++++
 rtl/if_fetch_buf.sv | 149 ++++++++++++++
 tb/tb_if_fetch_buf.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_buf_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the IF->ID bus layout (widened by the optional adef flag), the branch bus width and the PC reset default.
// Optional feature macro: IF_ADEF_EN (adds the fetch address-error flag as bus bit 64).
package if_fetch_buf_pkg;

  localparam int          BR_BUS_LEN       = 33;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h1C00_0000;

`ifdef IF_ADEF_EN
  typedef struct packed {
    logic        adef;
    logic [31:0] inst;
    logic [31:0] pc;
  } if_id_t;
`else
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } if_id_t;
`endif

  localparam int IF_ID_LEN = $bits(if_id_t);

endpackage

// File: rtl/if_fetch_buf_if.sv
// Split request/response SRAM-like instruction port (addr_ok accepts a request, data_ok returns one in order).
// master: fetch side driving req/addr and write-channel constants; slave: memory side returning addr_ok/data_ok/rdata.
// No clock inside; both sides sample on their own core clock.
interface if_fetch_buf_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );

  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );
endinterface

// File: rtl/if_fetch_buf_fetch_fifo.sv
// Small synchronous FIFO used for the in-flight PC queue and the instruction buffer.
// Ports: push_i/din_i write, pop_i advances head_o (first-word fall-through), flush_i empties (wins over push);
// full_o/empty_o/count_o report occupancy. Push while full is accepted only when a pop happens in the same cycle.
module if_fetch_buf_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/if_fetch_buf.sv
// Instruction fetch with up to OUTSTANDING split-transaction SRAM requests and an IBUF_DEPTH instruction buffer.
// Ports: clk/reset; id_allowin_i, br_bus_i, wb_exc_i, wb_ertn_i, csr_pc_i in; if_id_valid_o/if_id_bus_o to ID; sram (master).
// Latency: request the cycle after reset, instruction valid to ID the cycle after data_ok. Optional macro IF_ADEF_EN.
module if_fetch_buf
  import if_fetch_buf_pkg::*;
#(
  parameter logic [31:0] PC_RESET    = PC_RESET_DEFAULT,
  parameter int          IBUF_DEPTH  = 4,
  parameter int          OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_allowin_i,
  input  logic [BR_BUS_LEN-1:0] br_bus_i,
  input  logic                  wb_exc_i,
  input  logic                  wb_ertn_i,
  input  logic [31:0]           csr_pc_i,
  output logic                  if_id_valid_o,
  output logic [IF_ID_LEN-1:0]  if_id_bus_o,
  if_fetch_buf_if.master        sram
);

  localparam int QCW = $clog2(OUTSTANDING + 1);
  localparam int BCW = $clog2(IBUF_DEPTH + 1);

  logic            redirect;
  logic [31:0]     redirect_pc;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [QCW-1:0]  cancel_q, cancel_d;
  logic            credit_ok, misalign, accept, resp, resp_keep;
  logic            pq_full, pq_empty;
  logic [QCW-1:0]  pq_count;
  logic [31:0]     pq_head;
  logic            ib_push, ib_pop, ib_full, ib_empty;
  logic [BCW-1:0]  ib_count;
  if_id_t          ib_din, ib_head;

  assign redirect    = wb_exc_i | wb_ertn_i | br_bus_i[32];
  assign redirect_pc = (wb_exc_i | wb_ertn_i) ? csr_pc_i : br_bus_i[31:0];

  // Cancelled-but-unreturned requests still hold credits: their slot is needed until data_ok pops the PC queue.
  assign credit_ok = (int'(pq_count) < OUTSTANDING) &&
                     (int'(pq_count) + int'(ib_count) < IBUF_DEPTH);

  assign sram.inst_sram_req   = ~reset & ~redirect & ~misalign & credit_ok;
  assign sram.inst_sram_addr  = fetch_pc_q;
  assign sram.inst_sram_wr    = 1'b0;
  assign sram.inst_sram_size  = 2'b10;
  assign sram.inst_sram_wstrb = 4'h0;
  assign sram.inst_sram_wdata = 32'h0;

  assign accept    = sram.inst_sram_req & sram.inst_sram_addr_ok;
  assign resp      = sram.inst_sram_data_ok;
  assign resp_keep = resp & (cancel_q == '0) & ~redirect;

`ifdef IF_ADEF_EN
  logic adef_push, adef_done_q;

  // A misaligned PC produces exactly one error entry, then fetch parks until the next redirect.
  assign misalign  = (fetch_pc_q[1:0] != 2'b00);
  assign adef_push = ~reset & misalign & ~redirect & ~adef_done_q &
                     (pq_count == '0) & ~ib_full;
  assign ib_push   = resp_keep | adef_push;

  always_ff @(posedge clk) begin
    if (reset || redirect) adef_done_q <= 1'b0;
    else if (adef_push)    adef_done_q <= 1'b1;
  end

  always_comb begin
    ib_din      = '0;
    ib_din.inst = sram.inst_sram_rdata;
    ib_din.pc   = pq_head;
    if (adef_push) begin
      ib_din.adef = 1'b1;
      ib_din.inst = 32'h0;
      ib_din.pc   = fetch_pc_q;
    end
  end
`else
  assign misalign = 1'b0;
  assign ib_push  = resp_keep;

  always_comb begin
    ib_din      = '0;
    ib_din.inst = sram.inst_sram_rdata;
    ib_din.pc   = pq_head;
  end
`endif

  assign if_id_valid_o = ~ib_empty & ~redirect;
  assign if_id_bus_o   = ib_head;
  assign ib_pop        = if_id_valid_o & id_allowin_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    cancel_d   = cancel_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      // Every response still in flight after this cycle belongs to the old path.
      cancel_d   = pq_count - QCW'(resp);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (resp && cancel_q != '0) cancel_d = cancel_q - QCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= PC_RESET;
      cancel_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      cancel_q   <= cancel_d;
    end
  end

  // PC of each accepted request; its occupancy is the outstanding count. Never flushed: cancelled responses still pop it.
  if_fetch_buf_fetch_fifo #(.WIDTH(32), .DEPTH(OUTSTANDING)) u_pc_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (accept),
    .din_i   (fetch_pc_q),
    .pop_i   (resp),
    .flush_i (1'b0),
    .full_o  (pq_full),
    .empty_o (pq_empty),
    .count_o (pq_count),
    .head_o  (pq_head)
  );

  if_fetch_buf_fetch_fifo #(.WIDTH(IF_ID_LEN), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (ib_push),
    .din_i   (ib_din),
    .pop_i   (ib_pop),
    .flush_i (redirect),
    .full_o  (ib_full),
    .empty_o (ib_empty),
    .count_o (ib_count),
    .head_o  (ib_head)
  );

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset) !(resp && pq_empty));
  a_pq_room:        assert property (@(posedge clk) disable iff (reset) !(accept && pq_full));
  a_ib_room:        assert property (@(posedge clk) disable iff (reset) !(ib_push && ib_full && !ib_pop));

endmodule

// File: tb/tb_if_fetch_buf.sv
module tb_if_fetch_buf;
  import if_fetch_buf_pkg::*;

  localparam logic [31:0] PC_RST = 32'h1C00_0000;
  localparam int          OUTS   = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 id_allowin = 1'b0;
  logic [32:0]          br_bus = '0;
  logic                 wb_exc = 1'b0, wb_ertn = 1'b0;
  logic [31:0]          csr_pc = '0;
  logic                 if_id_valid;
  logic [IF_ID_LEN-1:0] if_id_bus;

  if_fetch_buf_if sram_if();

  if_fetch_buf #(.PC_RESET(PC_RST), .IBUF_DEPTH(4), .OUTSTANDING(OUTS)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_allowin_i (id_allowin),
    .br_bus_i     (br_bus),
    .wb_exc_i     (wb_exc),
    .wb_ertn_i    (wb_ertn),
    .csr_pc_i     (csr_pc),
    .if_id_valid_o(if_id_valid),
    .if_id_bus_o  (if_id_bus),
    .sram         (sram_if)
  );

  always #5 clk = ~clk;

  int          checks = 0, failures = 0, delivered = 0;
  logic [31:0] memq[$];          // addresses accepted by the memory, answered in order
  logic [31:0] exp_fetch, exp_id; // next fetch address / next PC ID must see on the current path
  bit          adef_stall = 0;
  bit          hs, acc, req_s, valid_s;
  logic [31:0] hs_pc, addr_s;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // One clock cycle: drive at negedge, sample 1 ns later, check against the path model, advance to next negedge.
  task automatic step(input bit allow, input bit br, input logic [31:0] bt, input bit exc,
                      input bit ertn, input logic [31:0] csr, input int aok_pct, input int dok_pct);
    bit redir, dok, bad, mis;
    logic [31:0] tgt;
    logic [IF_ID_LEN-1:0] exp_bus;
    id_allowin = allow; br_bus = {br, bt}; wb_exc = exc; wb_ertn = ertn; csr_pc = csr;
    sram_if.inst_sram_addr_ok = (int'($urandom_range(0, 99)) < aok_pct);
    dok = !reset && (memq.size() > 0) && (int'($urandom_range(0, 99)) < dok_pct);
    sram_if.inst_sram_data_ok = dok;
    sram_if.inst_sram_rdata   = dok ? inst_of(memq[0]) : 32'hDEAD_BEEF;
    #1;
    redir = br | exc | ertn;
    tgt   = (exc | ertn) ? csr : bt;
    req_s = sram_if.inst_sram_req; addr_s = sram_if.inst_sram_addr; valid_s = if_id_valid;
    hs = 0; acc = 0; hs_pc = 32'h0;
    if (reset) begin
      checks++;
      if (req_s !== 1'b0 || valid_s !== 1'b0) begin
        failures++; $display("FAIL reset_idle req=%b valid=%b required 0 0", req_s, valid_s);
      end
      memq.delete();
    end else begin
      if (req_s === 1'b1) begin
        bad = (addr_s !== exp_fetch) || redir || (sram_if.inst_sram_wr !== 1'b0) ||
              (sram_if.inst_sram_size !== 2'b10) || (sram_if.inst_sram_wstrb !== 4'h0) ||
              (sram_if.inst_sram_wdata !== 32'h0);
`ifdef IF_ADEF_EN
        bad = bad || (exp_fetch[1:0] != 2'b00);
`endif
        checks++;
        if (bad) begin
          failures++; $display("FAIL fetch_req addr=%h required %h redirect=%b", addr_s, exp_fetch, redir);
        end
        acc = sram_if.inst_sram_addr_ok;
      end
      if (redir) begin
        checks++;
        if (req_s !== 1'b0 || valid_s !== 1'b0) begin
          failures++; $display("FAIL redirect_quiet req=%b valid=%b required 0 0", req_s, valid_s);
        end
      end else if (valid_s === 1'b1 && allow) begin
        hs = 1; hs_pc = if_id_bus[31:0];
        exp_bus = '0; exp_bus[63:0] = {inst_of(exp_id), exp_id};
        mis = 0;
`ifdef IF_ADEF_EN
        mis = (exp_id[1:0] != 2'b00);
        if (mis) begin exp_bus = '0; exp_bus[64] = 1'b1; exp_bus[31:0] = exp_id; end
`endif
        checks++;
        if (if_id_bus !== exp_bus || adef_stall) begin
          failures++; $display("FAIL id_stream bus=%h required %h stalled=%b", if_id_bus, exp_bus, adef_stall);
        end
        if (mis) adef_stall = 1;
        exp_id += 32'd4;
        delivered++;
      end
      if (dok) void'(memq.pop_front());
      if (acc) memq.push_back(addr_s);
      if (redir) begin exp_fetch = tgt; exp_id = tgt; adef_stall = 0; end
      else if (acc) exp_fetch += 32'd4;
      checks++;
      if (memq.size() > OUTS) begin
        failures++; $display("FAIL outstanding_limit inflight=%0d required <=%0d", memq.size(), OUTS);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 100, 100);
  endtask

  task automatic first_hs(input int n, output bit found, output logic [31:0] pc);
    found = 0; pc = 32'h0;
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 0, 0, 0, 100, 100);
      if (hs && !found) begin found = 1; pc = hs_pc; end
    end
  endtask

  // Let everything in flight return and the buffer drain, with no new requests accepted.
  task automatic quiesce();
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0, 0, 100);
    checks++;
    if (valid_s !== 1'b0) begin failures++; $display("FAIL quiesce valid=%b required 0", valid_s); end
  endtask

  task automatic two_in_flight();
    int n = 0;
    quiesce();
    step(0, 0, 0, 0, 0, 0, 100, 0); n += int'(acc);
    step(0, 0, 0, 0, 0, 0, 100, 0); n += int'(acc);
    checks++;
    if (n != 2) begin failures++; $display("FAIL two_in_flight accepted=%0d required 2", n); end
  endtask

  task automatic drain_expect_nothing(input string name);
    int v = 0;
    for (int i = 0; i < 3; i++) begin step(1, 0, 0, 0, 0, 0, 0, 100); v += int'(valid_s); end
    checks++;
    if (v != 0) begin failures++; $display("FAIL %s wrong_path_valid=%0d required 0", name, v); end
  endtask

  task automatic expect_first(input string name, input logic [31:0] pc_exp);
    bit f; logic [31:0] pc;
    first_hs(8, f, pc);
    checks++;
    if (!f || pc !== pc_exp) begin failures++; $display("FAIL %s first_pc=%h found=%b required %h", name, pc, f, pc_exp); end
  endtask

  task automatic test_reset();
    reset = 1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 100, 100);
    reset = 0; exp_fetch = PC_RST; exp_id = PC_RST; adef_stall = 0;
    step(1, 0, 0, 0, 0, 0, 100, 100);
    checks++;
    if (!(req_s && acc && addr_s === PC_RST)) begin
      failures++; $display("FAIL first_req req=%b addr=%h required 1 %h", req_s, addr_s, PC_RST);
    end
    step(1, 0, 0, 0, 0, 0, 100, 100);
    checks++;
    if (valid_s !== 1'b0) begin failures++; $display("FAIL first_latency valid=%b required 0", valid_s); end
    step(1, 0, 0, 0, 0, 0, 100, 100);
    checks++;
    if (!hs || hs_pc !== PC_RST) begin failures++; $display("FAIL first_inst hs=%b pc=%h required 1 %h", hs, hs_pc, PC_RST); end
  endtask

  task automatic test_steady();
    int n = 0;
    for (int i = 0; i < 20; i++) begin step(1, 0, 0, 0, 0, 0, 100, 100); n += int'(hs); end
    checks++;
    if (n != 20) begin failures++; $display("FAIL steady_rate insts=%0d required 20", n); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    quiesce();
    step(1, 1, 32'h1C00_0400, 0, 0, 0, 100, 100);
    for (int i = 0; i < 10; i++) begin step(0, 0, 0, 0, 0, 0, 100, 100); n += int'(acc); end
    checks++;
    if (n != 4 || req_s !== 1'b0) begin failures++; $display("FAIL stall_credit accepted=%0d req=%b required 4 0", n, req_s); end
    step(1, 0, 0, 0, 0, 0, 100, 100);
    checks++;
    if (!hs || hs_pc !== 32'h1C00_0400) begin failures++; $display("FAIL release_head pc=%h required 1c000400", hs_pc); end
    n = 1;
    for (int i = 0; i < 7; i++) begin step(1, 0, 0, 0, 0, 0, 100, 100); n += int'(hs); end
    checks++;
    if (n != 8) begin failures++; $display("FAIL release_rate insts=%0d required 8", n); end
  endtask

  task automatic test_branch_cancel();
    two_in_flight();
    step(1, 1, 32'h1C00_0100, 0, 0, 0, 0, 0);
    drain_expect_nothing("branch_cancel");
    expect_first("branch_target", 32'h1C00_0100);
  endtask

  task automatic test_exc_priority();
    two_in_flight();
    step(1, 1, 32'h1C00_0100, 1, 0, 32'h1C00_8000, 0, 100);
    drain_expect_nothing("exc_cancel");
    expect_first("exc_priority", 32'h1C00_8000);
  endtask

  task automatic test_back_to_back();
    two_in_flight();
    step(1, 1, 32'h1C00_0300, 0, 0, 0, 0, 100);
    step(1, 0, 0, 0, 1, 32'h1C00_0500, 0, 0);
    drain_expect_nothing("b2b_cancel");
    expect_first("b2b_latest", 32'h1C00_0500);
  endtask

  task automatic test_addr_ok_stall();
    logic [31:0] a;
    quiesce();
    a = exp_fetch;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 100);
      checks++;
      if (req_s !== 1'b1 || addr_s !== a || acc) begin
        failures++; $display("FAIL addr_ok_stall req=%b addr=%h required 1 %h", req_s, addr_s, a);
      end
    end
    step(1, 0, 0, 0, 0, 0, 100, 100);
    checks++;
    if (!acc || addr_s !== a) begin failures++; $display("FAIL stall_release acc=%b addr=%h required 1 %h", acc, addr_s, a); end
  endtask

  task automatic test_wrap();
    int n = 0; bit saw_zero = 0;
    quiesce();
    step(1, 1, 32'hFFFF_FFF8, 0, 0, 0, 100, 100);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0, 0, 100, 100);
      n += int'(hs);
      if (hs && hs_pc == 32'h0) saw_zero = 1;
    end
    checks++;
    if (!saw_zero || n < 3) begin failures++; $display("FAIL pc_wrap saw_zero=%b insts=%0d required 1 >=3", saw_zero, n); end
  endtask

  task automatic test_misaligned();
    quiesce();
    step(1, 1, 32'h1C00_0002, 0, 0, 0, 100, 100);
`ifdef IF_ADEF_EN
    begin
      int r = 0, v = 0;
      for (int i = 0; i < 4; i++) begin step(0, 0, 0, 0, 0, 0, 100, 100); r += int'(req_s); end
      checks++;
      if (r != 0) begin failures++; $display("FAIL adef_no_req reqs=%0d required 0", r); end
      step(1, 0, 0, 0, 0, 0, 100, 100);
      checks++;
      if (!hs || hs_pc !== 32'h1C00_0002 || if_id_bus[64] !== 1'b1) begin
        failures++; $display("FAIL adef_entry hs=%b bus=%h required adef pc 1c000002", hs, if_id_bus);
      end
      for (int i = 0; i < 4; i++) begin step(1, 0, 0, 0, 0, 0, 100, 100); v += int'(valid_s); end
      checks++;
      if (v != 0) begin failures++; $display("FAIL adef_stall valid_cycles=%0d required 0", v); end
      step(1, 1, 32'h1C00_0200, 0, 0, 0, 100, 100);
      expect_first("adef_resume", 32'h1C00_0200);
    end
`else
    expect_first("unaligned_pass", 32'h1C00_0002);
`endif
  endtask

  task automatic test_random();
    int d0 = delivered;
    for (int i = 0; i < 2500; i++) begin
      int k = int'($urandom_range(0, 99));
      logic [31:0] bt = {16'h1C00, 14'($urandom), 2'b00};
      logic [31:0] ct = {16'h1C01, 14'($urandom), 2'b00};
      step(int'($urandom_range(0, 99)) < 75, (k < 5), bt, (k == 4 || k == 5), (k == 6), ct, 60, 60);
    end
    checks++;
    if (delivered - d0 < 200) begin failures++; $display("FAIL random_progress insts=%0d required >=200", delivered - d0); end
  endtask

  initial begin
    sram_if.inst_sram_addr_ok = 1'b0;
    sram_if.inst_sram_data_ok = 1'b0;
    sram_if.inst_sram_rdata   = 32'h0;
    @(negedge clk);
    test_reset();
    test_steady();
    test_backpressure();
    test_branch_cancel();
    test_exc_priority();
    test_back_to_back();
    test_addr_ok_stall();
    test_wrap();
    test_misaligned();
    test_random();
    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
